// File: rtl/mac_array_ctrl_pkg.sv
// Shared types and constants for the MAC-array sequencer: FSM states,
// west-edge instruction codes and the GAP / DRAIN cycle lengths.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_EXEC,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam int ROW_DEF    = 8;
    localparam int COL_DEF    = 8;
    localparam int LEN_BW_DEF = 8;

    // A kernel load needs one bubble per column to reach the far edge.
    function automatic int gap_cycles(input int col);
        return col;
    endfunction

    // Drain covers the input skew plus partial-sum travel across the array.
    function automatic int drain_cycles(input int row, input int col);
        return row + col;
    endfunction

    localparam int GAP_LEN   = gap_cycles(COL_DEF);
    localparam int DRAIN_LEN = drain_cycles(ROW_DEF, COL_DEF);

endpackage

// File: rtl/mac_array_ctrl_if.sv
// Job-request, L0 FIFO and array-edge signals of the MAC-array sequencer.
interface mac_array_ctrl_if
    import mac_ctrl_pkg::*;
#(
    parameter int LEN_BW = LEN_BW_DEF
);
    logic              start;
    logic              mode_os;
    logic [LEN_BW-1:0] exec_len;
    logic              l0_empty;
    logic              l0_rd;
    logic [1:0]        inst_w;
    logic              mode_sel;
    logic              busy;
    logic              done;

    modport master (
        output start, mode_os, exec_len, l0_empty,
        input  l0_rd, inst_w, mode_sel, busy, done
    );

    modport slave (
        input  start, mode_os, exec_len, l0_empty,
        output l0_rd, inst_w, mode_sel, busy, done
    );
endinterface

// File: rtl/mac_array_ctrl_cnt.sv
// Clearable up-counter with flags for "count equals term" and
// "next increment reaches term".
module ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o   = (cnt_q == term_i);
    assign last_o = (cnt_inc == term_i);
endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for the MAC array: pops L0 vectors and issues kernel-load /
// execute instructions to the west edge, then drains and pulses done.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROW    = ROW_DEF,
    parameter int COL    = COL_DEF,
    parameter int LEN_BW = LEN_BW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mac_array_ctrl_if.slave  bus
);
    localparam logic [LEN_BW-1:0] LOAD_TERM  = LEN_BW'(COL);
    localparam logic [LEN_BW-1:0] GAP_TERM   = LEN_BW'(gap_cycles(COL));
    localparam logic [LEN_BW-1:0] DRAIN_TERM = LEN_BW'(drain_cycles(ROW, COL));

    state_e            state_q, state_d;
    logic [LEN_BW-1:0] len_q, len_d;
    logic              mode_q, mode_d;
    logic [1:0]        inst_q, inst_d;

    logic              pop;
    logic              pop_tc, pop_last;
    logic              tmr_tc, tmr_last;
    logic              state_chg;
    logic [LEN_BW-1:0] pop_term, tmr_term;
    logic              unused_tmr_tc;

    assign unused_tmr_tc = tmr_tc;
    assign state_chg     = (state_d != state_q);
    assign pop_term      = (state_q == ST_LOAD) ? LOAD_TERM : len_q;
    assign tmr_term      = (state_q == ST_GAP)  ? GAP_TERM  : DRAIN_TERM;

    // pop_tc means the pop counter has reached its target: nothing left to pop.
    assign pop = ((state_q == ST_LOAD) || (state_q == ST_EXEC))
                 && !bus.l0_empty && !pop_tc;

    // Both counters restart from zero whenever the FSM changes state.
    ctrl_cnt #(.W(LEN_BW)) u_pop_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_chg),
        .en_i   (pop),
        .term_i (pop_term),
        .tc_o   (pop_tc),
        .last_o (pop_last)
    );

    ctrl_cnt #(.W(LEN_BW)) u_tmr_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_chg),
        .en_i   ((state_q == ST_GAP) || (state_q == ST_DRAIN)),
        .term_i (tmr_term),
        .tc_o   (tmr_tc),
        .last_o (tmr_last)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        mode_d  = mode_q;
        inst_d  = INST_IDLE;
        if (pop) begin
            inst_d = (state_q == ST_LOAD) ? INST_LOAD : INST_EXEC;
        end
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = bus.exec_len;
                    mode_d  = bus.mode_os;
                    state_d = bus.mode_os ? ST_EXEC : ST_LOAD;
                end
            end
            ST_LOAD:  if (pop && pop_last) state_d = ST_GAP;
            ST_GAP:   if (tmr_last) state_d = (len_q == '0) ? ST_DRAIN : ST_EXEC;
            // A zero-length OS job leaves EXEC on its first cycle without popping.
            ST_EXEC:  if (pop_tc || (pop && pop_last)) state_d = ST_DRAIN;
            ST_DRAIN: if (tmr_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            mode_q  <= 1'b0;
            inst_q  <= INST_IDLE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.l0_rd    = pop;
    assign bus.inst_w   = inst_q;
    assign bus.mode_sel = mode_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl: per-cycle expected outputs are queued
// from the job timeline and compared as each cycle is observed.
module tb_mac_array_ctrl;
    import mac_ctrl_pkg::*;

    typedef struct {
        logic       rd;
        logic [1:0] inst;
        logic       busy;
        logic       done;
        logic       mode;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_array_ctrl_if #(.LEN_BW(8)) bus ();

    mac_array_ctrl #(.ROW(8), .COL(8), .LEN_BW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    logic [1:0] prev_code = INST_IDLE;
    logic       cur_mode = 1'b0;
    string      job = "reset";

    // inst_w in a cycle is the code of the pop expected in the previous cycle.
    function automatic void push(input int n, input logic rd, input logic [1:0] code,
                                 input logic busy, input logic done);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.rd   = rd;
            e.inst = prev_code;
            e.busy = busy;
            e.done = done;
            e.mode = cur_mode;
            sb_q.push_back(e);
            prev_code = rd ? code : INST_IDLE;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_cycle(input int k);
        exp_t e;
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.done === 1'b1) done_cnt++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("%s l0_rd@%0d", job, k),    32'(bus.l0_rd),    32'(e.rd));
            chk($sformatf("%s inst_w@%0d", job, k),   32'(bus.inst_w),   32'(e.inst));
            chk($sformatf("%s busy@%0d", job, k),     32'(bus.busy),     32'(e.busy));
            chk($sformatf("%s done@%0d", job, k),     32'(bus.done),     32'(e.done));
            chk($sformatf("%s mode_sel@%0d", job, k), 32'(bus.mode_sel), 32'(e.mode));
        end
    endtask

    // k = 0 is the start cycle; st_a/st_b inject extra (ignored) starts with
    // altered mode/length, tog_last toggles l0_empty in cycles 1..tog_last.
    task automatic run_job(input logic mo, input logic [7:0] el, input int ncyc,
                           input int tog_last, input int st_a, input int st_b,
                           input int rst_at);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            bus.start    = (k == 0) || (k == st_a) || (k == st_b);
            bus.mode_os  = (k == 0) ? mo : ~mo;
            bus.exec_len = (k == 0) ? el : el + 8'd7;
            bus.l0_empty = (k >= 1 && k <= tog_last) ? (k % 2 == 1) : 1'b0;
            reset        = (k == rst_at);
            #1;
            check_cycle(k);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.mode_os  = 1'b0;
        bus.exec_len = 8'd0;
        bus.l0_empty = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset inst_w",   32'(bus.inst_w),   32'd0);
        chk("reset busy",     32'(bus.busy),     32'd0);
        chk("reset done",     32'(bus.done),     32'd0);
        chk("reset l0_rd",    32'(bus.l0_rd),    32'd0);
        chk("reset mode_sel", 32'(bus.mode_sel), 32'd0);

        // WS, len 5, FIFO never empty: 39 cycles from start to done inclusive.
        job = "ws5";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b0;
        push(8, 1, INST_LOAD, 1, 0);
        push(8, 0, INST_IDLE, 1, 0);
        push(5, 1, INST_EXEC, 1, 0);
        push(16, 0, INST_IDLE, 1, 0);
        push(1, 0, INST_IDLE, 1, 1);
        push(1, 0, INST_IDLE, 0, 0);
        done_cnt = 0;
        run_job(1'b0, 8'd5, 40, 0, -1, -1, -1);
        chk("ws5 done count", 32'(done_cnt), 32'd1);

        // OS, len 3: no kernel load.
        job = "os3";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b1;
        push(3, 1, INST_EXEC, 1, 0);
        push(16, 0, INST_IDLE, 1, 0);
        push(1, 0, INST_IDLE, 1, 1);
        push(1, 0, INST_IDLE, 0, 0);
        run_job(1'b1, 8'd3, 22, 0, -1, -1, -1);

        // WS, len 2, l0_empty high on odd cycles during LOAD: pops on even cycles.
        job = "ws_stall";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push(1, 0, INST_LOAD, 1, 0);
            push(1, 1, INST_LOAD, 1, 0);
        end
        push(8, 0, INST_IDLE, 1, 0);
        push(2, 1, INST_EXEC, 1, 0);
        push(16, 0, INST_IDLE, 1, 0);
        push(1, 0, INST_IDLE, 1, 1);
        push(1, 0, INST_IDLE, 0, 0);
        run_job(1'b0, 8'd2, 45, 16, -1, -1, -1);

        // OS, len 3 with starts in EXEC (k=2) and DONE (k=20): both ignored.
        job = "os3_ign";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b1;
        push(3, 1, INST_EXEC, 1, 0);
        push(16, 0, INST_IDLE, 1, 0);
        push(1, 0, INST_IDLE, 1, 1);
        push(2, 0, INST_IDLE, 0, 0);
        done_cnt = 0;
        run_job(1'b1, 8'd3, 23, 0, 2, 20, -1);
        chk("os3_ign done count", 32'(done_cnt), 32'd1);

        // OS, len 5, reset in the third EXEC cycle: job abandoned, no done.
        job = "os5_rst";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b1;
        push(3, 1, INST_EXEC, 1, 0);
        prev_code = INST_IDLE;
        cur_mode  = 1'b0;
        push(2, 0, INST_IDLE, 0, 0);
        done_cnt = 0;
        run_job(1'b1, 8'd5, 6, 0, -1, -1, 3);
        chk("os5_rst done count", 32'(done_cnt), 32'd0);

        // Fresh WS job after the reset.
        job = "ws2_after";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b0;
        push(8, 1, INST_LOAD, 1, 0);
        push(8, 0, INST_IDLE, 1, 0);
        push(2, 1, INST_EXEC, 1, 0);
        push(16, 0, INST_IDLE, 1, 0);
        push(1, 0, INST_IDLE, 1, 1);
        push(1, 0, INST_IDLE, 0, 0);
        run_job(1'b0, 8'd2, 37, 0, -1, -1, -1);

        // OS, len 0: busy for exactly row+col+2 cycles, no pops.
        job = "os0";
        push(1, 0, INST_IDLE, 0, 0);
        cur_mode = 1'b1;
        push(1, 0, INST_IDLE, 1, 0);
        push(16, 0, INST_IDLE, 1, 0);
        push(1, 0, INST_IDLE, 1, 1);
        push(1, 0, INST_IDLE, 0, 0);
        busy_cnt = 0;
        run_job(1'b1, 8'd0, 20, 0, -1, -1, -1);
        chk("os0 busy cycles", 32'(busy_cnt), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
